// File: rtl/sipo_frame_ctrl_if.sv
// sipo_frame_ctrl_if: serial-in / parallel-out frame bus between a producer/consumer (master) and sipo_frame_ctrl (slave).
interface sipo_frame_ctrl_if #(parameter int WIDTH = 4);
    logic             si;
    logic             start;
    logic             po_ready;
    logic             shift_en;
    logic [WIDTH-1:0] po;
    logic             po_valid;
    logic             busy;
    logic             overrun;
    logic             parity_err;
    modport master (output si, start, po_ready, input shift_en, po, po_valid, busy, overrun, parity_err);
    modport slave  (input si, start, po_ready, output shift_en, po, po_valid, busy, overrun, parity_err);
endinterface

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: start-triggered serial-to-parallel framer with ready/valid output and sticky overrun flag.
// Define SIPO_FRAME_PARITY_EN to sample a trailing even-parity bit per frame and report parity_err.
module sipo_frame_ctrl #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    sipo_frame_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, HOLD} state_t;
`ifdef SIPO_FRAME_PARITY_EN
    localparam state_t AFTER_SHIFT = PARITY;
`else
    localparam state_t AFTER_SHIFT = HOLD;
`endif
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d, po_q, po_d;
    logic             po_valid_q, po_valid_d, overrun_q, overrun_d;
    logic             last_bit, hs, enter_hold, shift_en, busy;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? SHIFT : IDLE;
            SHIFT:   state_d = last_bit ? AFTER_SHIFT : SHIFT;
            PARITY:  state_d = HOLD;
            HOLD:    state_d = bus.po_ready ? (bus.start ? SHIFT : IDLE) : HOLD;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        shift_en = state_q == SHIFT;
        busy     = state_q != IDLE;
    end
    always_comb begin
        last_bit   = cnt_q == CW'(WIDTH - 1);
        hs         = state_q == HOLD && bus.po_ready;
        enter_hold = state_d == HOLD && state_q != HOLD;
        cnt_d      = (state_d == SHIFT && state_q != SHIFT) ? '0 : (state_q == SHIFT) ? cnt_q + CW'(1) : cnt_q;
        sr_d       = (state_q == SHIFT) ? {sr_q[WIDTH-2:0], bus.si} : sr_q;
        po_d       = enter_hold ? sr_d : po_q;
        po_valid_d = enter_hold | (po_valid_q & ~hs);
        overrun_d  = overrun_q | (state_q == HOLD && bus.start && !bus.po_ready);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            sr_q       <= '0;
            po_q       <= '0;
            po_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            po_q       <= po_d;
            po_valid_q <= po_valid_d;
            overrun_q  <= overrun_d;
        end
    end
`ifdef SIPO_FRAME_PARITY_EN
    logic parity_err_q, parity_err_d;
    // PARITY always leads straight into HOLD, so this is exactly the HOLD-entry update.
    always_comb parity_err_d = (state_q == PARITY) ? ^{sr_q, bus.si} : parity_err_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) parity_err_q <= 1'b0;
        else      parity_err_q <= parity_err_d;
    end
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
    assign bus.shift_en = shift_en;
    assign bus.busy     = busy;
    assign bus.po       = po_q;
    assign bus.po_valid = po_valid_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: vector table, directed corner sequences and random frames against a frame-level model.
module tb_sipo_frame_ctrl;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_ovr = 1'b0;
    sipo_frame_ctrl_if #(.WIDTH(W)) bus();
    sipo_frame_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic [W-1:0] data;
        logic         pbit;
        int           dly;
        bit           sis;
        logic [W-1:0] exp_po;
        logic         exp_perr;
    } vec_t;
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic chk_perr(input logic ep);
`ifdef SIPO_FRAME_PARITY_EN
        chk("parity_err", bus.parity_err, ep);
`else
        chk("parity_err", bus.parity_err, {15'b0, ep & 1'b0});
`endif
    endtask
    // Start edge, then one data bit per edge (first bit = MSB), optional parity edge; po_valid must rise on the last one.
    task automatic send_frame(input logic [W-1:0] d, input logic pb, input bit hs, input bit sis,
                              input logic [W-1:0] exp, input logic ep);
        @(negedge clk);
        bus.start = 1'b1;
        bus.po_ready = hs;
        bus.si = $urandom_range(0, 1);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("shift_en_in_frame", bus.shift_en, 1);
            chk("busy_in_frame", bus.busy, 1);
            chk("po_valid_early", bus.po_valid, 0);
            bus.po_ready = 1'b0;
            bus.start = sis && i == 1;
            bus.si = d[W-1-i];
        end
`ifdef SIPO_FRAME_PARITY_EN
        @(negedge clk);
        chk("shift_en_parity", bus.shift_en, 0);
        chk("po_valid_parity", bus.po_valid, 0);
        bus.start = 1'b0;
        bus.si = pb;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        bus.si = 1'b0;
        chk("po_valid_latency", bus.po_valid, 1);
        chk("shift_en_hold", bus.shift_en, 0);
        chk("busy_hold", bus.busy, 1);
        chk("po", bus.po, exp);
        chk("overrun", bus.overrun, exp_ovr);
        chk_perr(ep);
    endtask
    // Stall dly cycles in HOLD (optionally firing start without ready midway), then handshake.
    task automatic accept(input int dly, input bit ovr, input logic [W-1:0] exp);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("po_valid_stall", bus.po_valid, 1);
            chk("po_stall", bus.po, exp);
            bus.po_ready = 1'b0;
            bus.start = ovr && i == dly / 2;
        end
        @(negedge clk);
        chk("po_valid_pre_hs", bus.po_valid, 1);
        chk("po_pre_hs", bus.po, exp);
        bus.start = 1'b0;
        bus.po_ready = 1'b1;
        @(negedge clk);
        bus.po_ready = 1'b0;
        chk("po_valid_post_hs", bus.po_valid, 0);
        chk("busy_post_hs", bus.busy, 0);
        chk("po_kept", bus.po, exp);
        if (ovr && dly > 0) exp_ovr = 1'b1;
        chk("overrun_post_hs", bus.overrun, exp_ovr);
    endtask
    task automatic chk_reset_state();
        chk("rst_po", bus.po, 0);
        chk("rst_po_valid", bus.po_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_shift_en", bus.shift_en, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_parity_err", bus.parity_err, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang expected finish");
        $fatal(1);
    end
    initial begin
        vec_t vecs[7];
        logic [W-1:0] d;
        logic pb;
        int dly;
        bit ovr, sis;
        vecs[0] = '{4'b1011, 1'b0, 2, 1'b0, 4'b1011, 1'b1};
        vecs[1] = '{4'b1011, 1'b1, 0, 1'b1, 4'b1011, 1'b0};
        vecs[2] = '{4'b0110, 1'b0, 1, 1'b0, 4'b0110, 1'b0};
        vecs[3] = '{4'b0000, 1'b1, 3, 1'b1, 4'b0000, 1'b1};
        vecs[4] = '{4'b1111, 1'b0, 0, 1'b0, 4'b1111, 1'b0};
        vecs[5] = '{4'b1000, 1'b1, 4, 1'b1, 4'b1000, 1'b0};
        vecs[6] = '{4'b0001, 1'b0, 2, 1'b0, 4'b0001, 1'b1};
        bus.si = 1'b0;
        bus.start = 1'b0;
        bus.po_ready = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_state();
        rst = 1'b1;
        foreach (vecs[k]) begin
            send_frame(vecs[k].data, vecs[k].pbit, 1'b0, vecs[k].sis, vecs[k].exp_po, vecs[k].exp_perr);
            accept(vecs[k].dly, 1'b0, vecs[k].exp_po);
            chk_perr(vecs[k].exp_perr);
        end
        // Back-to-back: handshake and new start on the same HOLD edge.
        send_frame(4'b1011, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b0);
        send_frame(4'b0110, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b0);
        accept(0, 1'b0, 4'b0110);
        // Backpressure with a lost start: overrun sticks, word survives.
        send_frame(4'b1011, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1);
        accept(10, 1'b1, 4'b1011);
        send_frame(4'b0101, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b0);
        accept(1, 1'b0, 4'b0101);
        // Reset two bits into a frame, then a clean frame.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.si = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_ovr = 1'b0;
        #1 chk_reset_state();
        chk("rst_async_mid", bus.busy, 0);
        repeat (2) @(negedge clk);
        chk_reset_state();
        rst = 1'b1;
        send_frame(4'b1100, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0);
        accept(0, 1'b0, 4'b1100);
        for (int n = 0; n < 40; n++) begin
            d = W'($urandom);
            pb = 1'($urandom);
            dly = $urandom_range(0, 5);
            ovr = ($urandom_range(0, 3) == 0);
            sis = 1'($urandom);
            send_frame(d, pb, 1'b0, sis, d, ^{d, pb});
            accept(dly, ovr, d);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
